// File: rtl/proc_pkg.sv
//------------------------------------------------------------------------------
// proc_pkg - state codes, opcodes and datapath defaults shared with the sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int STATE_W    = 6;

  localparam logic [STATE_W-1:0] ST_IDLE = 6'd0;
  localparam logic [STATE_W-1:0] ST_F1   = 6'd1;
  localparam logic [STATE_W-1:0] ST_F2   = 6'd2;
  localparam logic [STATE_W-1:0] ST_F3   = 6'd3;
  localparam logic [STATE_W-1:0] ST_L1_1 = 6'd4;
  localparam logic [STATE_W-1:0] ST_L1_2 = 6'd5;
  localparam logic [STATE_W-1:0] ST_L1_3 = 6'd6;
  localparam logic [STATE_W-1:0] ST_L1_4 = 6'd7;
  localparam logic [STATE_W-1:0] ST_L2_1 = 6'd8;
  localparam logic [STATE_W-1:0] ST_L2_2 = 6'd9;
  localparam logic [STATE_W-1:0] ST_L2_3 = 6'd10;
  localparam logic [STATE_W-1:0] ST_L2_4 = 6'd11;
  localparam logic [STATE_W-1:0] ST_S1   = 6'd12;
  localparam logic [STATE_W-1:0] ST_S2   = 6'd13;
  localparam logic [STATE_W-1:0] ST_S3   = 6'd14;
  localparam logic [STATE_W-1:0] ST_S4   = 6'd15;
  localparam logic [STATE_W-1:0] ST_ADD  = 6'd16;
  localparam logic [STATE_W-1:0] ST_MUL  = 6'd17;

  localparam logic [5:0] OP_HALT = 6'd0;
  localparam logic [5:0] OP_LDR1 = 6'd1;
  localparam logic [5:0] OP_LDR2 = 6'd2;
  localparam logic [5:0] OP_STAC = 6'd3;
  localparam logic [5:0] OP_ADD  = 6'd4;
  localparam logic [5:0] OP_MUL  = 6'd5;

  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    return (s <= ST_MUL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_alu.sv
//------------------------------------------------------------------------------
// cu_alu - combinational add-with-carry and multiply-with-overflow
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cu_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out,
  output logic [DATA_W-1:0] prod_lo,
  output logic              prod_ovf
);

  logic [2*DATA_W-1:0] prod;

  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b};
    prod             = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_lo          = prod[DATA_W-1:0];
    prod_ovf         = |prod[2*DATA_W-1:DATA_W];
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// control_unit - decodes sequencer state into RAM strobes and register loads
// Rev 1.0; optional retired-instruction counter via CONTROL_UNIT_PERF_CNT_EN
//------------------------------------------------------------------------------
`default_nettype none

module control_unit
  import proc_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [STATE_W-1:0]  state,
  output logic [DATA_W-1:0]   IR,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   AC,
  output logic                carry,
  output logic                ovf,
  output logic                halted,
  output logic                err_illegal,
  output logic [15:0]         retired_count
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  ar;
  logic [DATA_W-1:0]  r1;
  logic [DATA_W-1:0]  r2;
  logic [STATE_W-1:0] prev_state;

  logic [DATA_W-1:0]  alu_sum;
  logic               alu_carry;
  logic [DATA_W-1:0]  alu_prod;
  logic               alu_ovf;

  logic [ADDR_W-1:0]  operand;
  assign operand = IR[ADDR_W-1:0];

  cu_alu #(.DATA_W(DATA_W)) u_alu (
    .a         (r1),
    .b         (r2),
    .sum       (alu_sum),
    .carry_out (alu_carry),
    .prod_lo   (alu_prod),
    .prod_ovf  (alu_ovf)
  );

  // Strobes are a pure function of state; the address rests on AR when idle.
  always_comb begin
    mem_addr = ar;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state)
      ST_F1: begin
        mem_addr = pc;
        mem_rd   = 1'b1;
      end
      ST_L1_2, ST_L2_2: mem_rd = 1'b1;
      ST_S3:            mem_wr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= PC_RESET;
      IR          <= '0;
      ar          <= '0;
      r1          <= '0;
      r2          <= '0;
      AC          <= '0;
      mem_wdata   <= '0;
      carry       <= 1'b0;
      ovf         <= 1'b0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
      prev_state  <= ST_IDLE;
    end else begin
      prev_state <= state;
      case (state)
        ST_IDLE: if (prev_state == ST_F3) halted <= 1'b1;
        ST_F1:   pc <= pc + ADDR_W'(1);
        ST_F2:   IR <= mem_rdata;
        ST_L1_1, ST_L2_1, ST_S1: ar <= operand;
        ST_L1_3: r1 <= mem_rdata;
        ST_L2_3: r2 <= mem_rdata;
        ST_S2:   mem_wdata <= AC;
        ST_ADD: begin
          AC    <= alu_sum;
          carry <= alu_carry;
        end
        ST_MUL: begin
          AC  <= alu_prod;
          ovf <= alu_ovf;
        end
        default: if (!is_legal_state(state)) err_illegal <= 1'b1;
      endcase
    end
  end

`ifdef CONTROL_UNIT_PERF_CNT_EN
  logic [15:0] retired_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state == ST_F3 && retired_q != 16'hFFFF) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// tb_control_unit - directed test-plan sequences plus random state streams vs a model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;
  import proc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
`ifdef CONTROL_UNIT_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    state = ST_IDLE;
  logic [DW-1:0] IR;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] AC;
  logic          carry;
  logic          ovf;
  logic          halted;
  logic          err_illegal;
  logic [15:0]   retired_count;

  control_unit dut (
    .clock(clock), .reset(reset), .state(state), .IR(IR),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .AC(AC),
    .carry(carry), .ovf(ovf), .halted(halted),
    .err_illegal(err_illegal), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // Single-port RAM with one-cycle read latency; bench preload port shares it.
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q = '0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [DW-1:0] tb_wd = '0;

  always @(posedge clock) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fetch  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  task automatic step(input logic [5:0] s, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input bit chk_a, input string tag);
    @(negedge clock);
    state = s;
    #1;
    check({tag, ".rd"}, mem_rd, rd);
    check({tag, ".wr"}, mem_wr, wr);
    if (chk_a) check({tag, ".addr"}, mem_addr, a);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] pc, input logic [DW-1:0] ir);
    step(ST_F1, 1, 0, pc, 1, "F1");
    step(ST_F2, 0, 0, '0, 0, "F2");
    check("IR.F2", IR, ir);
    step(ST_F3, 0, 0, '0, 0, "F3");
    check("IR.F3", IR, ir);
    n_fetch++;
    check("retired", retired_count, PERF ? n_fetch : 0);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] m_mem [0:1023];
  logic [DW-1:0] m_q, m_ir, m_r1, m_r2, m_ac, m_wdata;
  logic [AW-1:0] m_pc, m_ar;
  logic          m_c, m_o, m_halt, m_err;
  logic [5:0]    m_prev;
  logic [15:0]   m_cnt;

  task automatic model_reset();
    m_pc = '0; m_ar = '0; m_ir = '0; m_r1 = '0; m_r2 = '0; m_ac = '0;
    m_wdata = '0; m_c = 0; m_o = 0; m_halt = 0; m_err = 0;
    m_prev = ST_IDLE; m_cnt = '0;
  endtask

  task automatic model_comb(input logic [5:0] s, output bit rd, output bit wr,
                            output logic [AW-1:0] a);
    a  = m_ar;
    rd = (s == ST_F1) || (s == ST_L1_2) || (s == ST_L2_2);
    wr = (s == ST_S3);
    if (s == ST_F1) a = m_pc;
  endtask

  task automatic model_clock(input logic [5:0] s, input bit rd, input bit wr,
                             input logic [AW-1:0] a);
    logic [DW-1:0] q_now;
    logic [DW:0]   sum;
    logic [31:0]   p;
    q_now = m_q;
    sum   = 17'(m_r1) + 17'(m_r2);
    p     = 32'(m_r1) * 32'(m_r2);
    if (wr) m_mem[a] = m_wdata;
    if (rd) m_q = m_mem[a];
    if (s == ST_IDLE && m_prev == ST_F3) m_halt = 1;
    if (s == ST_F1) m_pc = m_pc + 1'b1;
    if (s == ST_F2) m_ir = q_now;
    if (s == ST_L1_1 || s == ST_L2_1 || s == ST_S1) m_ar = m_ir[AW-1:0];
    if (s == ST_L1_3) m_r1 = q_now;
    if (s == ST_L2_3) m_r2 = q_now;
    if (s == ST_S2) m_wdata = m_ac;
    if (s == ST_ADD) {m_c, m_ac} = sum;
    if (s == ST_MUL) begin
      m_ac = p[15:0];
      m_o  = (p[31:16] != 16'd0);
    end
    if (s > 6'd17) m_err = 1;
    if (PERF && s == ST_F3 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    m_prev = s;
  endtask

  // Operand pairs and the operation applied to them
  logic [DW-1:0] va  [5] = '{16'h1234, 16'hFFFF, 16'h0100, 16'h0003, 16'hBEEF};
  logic [DW-1:0] vb  [5] = '{16'h0F00, 16'h0001, 16'h0100, 16'h0004, 16'h0000};
  logic [5:0]    vop [5] = '{ST_ADD,   ST_ADD,   ST_MUL,   ST_MUL,   ST_ADD};
  logic [DW-1:0] eac [5] = '{16'h2134, 16'h0000, 16'h0000, 16'h000C, 16'hBEEF};
  logic          ec  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic          eo  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [AW-1:0] aa, ab;
    bit            erd, ewr;
    logic [AW-1:0] ea;
    logic [5:0]    s;

    #2;
    check("rst.IR", IR, 0);
    check("rst.AC", AC, 0);
    check("rst.wdata", mem_wdata, 0);
    check("rst.flags", {carry, ovf, halted, err_illegal}, 0);
    check("rst.strobes", {mem_rd, mem_wr}, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.retired", retired_count, 0);

    for (int i = 0; i < 1024; i++) poke(AW'(i), DW'($urandom));
    for (int i = 0; i < 5; i++) begin
      aa = AW'(10'h100 + 2 * i);
      ab = AW'(10'h101 + 2 * i);
      poke(AW'(2 * i),     {OP_LDR1, aa});
      poke(AW'(2 * i + 1), {OP_LDR2, ab});
      poke(aa, va[i]);
      poke(ab, vb[i]);
    end
    poke(10'd10, {OP_STAC, 10'h3FF});
    poke(10'd11, 16'h0000);
    poke(10'h3FF, 16'h0000);

    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      aa = AW'(10'h100 + 2 * i);
      ab = AW'(10'h101 + 2 * i);
      fetch(AW'(2 * i), {OP_LDR1, aa});
      step(ST_L1_1, 0, 0, '0, 0, "L1_1");
      step(ST_L1_2, 1, 0, aa, 1, "L1_2");
      step(ST_L1_3, 0, 0, '0, 0, "L1_3");
      check("R1", dut.r1, va[i]);
      step(ST_L1_4, 0, 0, '0, 0, "L1_4");
      fetch(AW'(2 * i + 1), {OP_LDR2, ab});
      step(ST_L2_1, 0, 0, '0, 0, "L2_1");
      step(ST_L2_2, 1, 0, ab, 1, "L2_2");
      step(ST_L2_3, 0, 0, '0, 0, "L2_3");
      check("R2", dut.r2, vb[i]);
      step(ST_L2_4, 0, 0, '0, 0, "L2_4");
      step(vop[i], 0, 0, '0, 0, "EXEC");
      check("AC", AC, eac[i]);
      check("carry", carry, ec[i]);
      check("ovf", ovf, eo[i]);
    end

    fetch(10'd10, {OP_STAC, 10'h3FF});
    step(ST_S1, 0, 0, '0, 0, "S1");
    step(ST_S2, 0, 0, '0, 0, "S2");
    check("wdata", mem_wdata, 16'hBEEF);
    step(ST_S3, 0, 1, 10'h3FF, 1, "S3");
    step(ST_S4, 0, 0, '0, 0, "S4");
    check("ram3FF", ram[10'h3FF], 16'hBEEF);

    fetch(10'd11, 16'h0000);
    check("halt.pre", halted, 0);
    step(ST_IDLE, 0, 0, '0, 0, "IDLE");
    check("halted", halted, 1);
    step(6'd40, 0, 0, '0, 0, "ILL");
    check("err", err_illegal, 1);
    check("halt.sticky", halted, 1);

    // Asynchronous reset in the middle of S3
    @(negedge clock);
    state = ST_S3;
    #1;
    check("S3b.wr", mem_wr, 1);
    #2;
    reset = 1'b1;
    state = ST_IDLE;
    #1;
    check("arst.IR", IR, 0);
    check("arst.AC", AC, 0);
    check("arst.wdata", mem_wdata, 0);
    check("arst.flags", {carry, ovf, halted, err_illegal}, 0);
    check("arst.strobes", {mem_rd, mem_wr}, 0);
    check("arst.addr", mem_addr, 0);
    check("arst.retired", retired_count, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    model_reset();
    for (int i = 0; i < 1024; i++) m_mem[i] = ram[i];
    m_q = ram_q;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      model_comb(s, erd, ewr, ea);
      @(negedge clock);
      state = s;
      #1;
      check("rnd.rd", mem_rd, erd);
      check("rnd.wr", mem_wr, ewr);
      check("rnd.addr", mem_addr, ea);
      @(posedge clock);
      #1;
      model_clock(s, erd, ewr, ea);
      check("rnd.IR", IR, m_ir);
      check("rnd.AC", AC, m_ac);
      check("rnd.wdata", mem_wdata, m_wdata);
      check("rnd.flags", {carry, ovf, halted, err_illegal}, {m_c, m_o, m_halt, m_err});
      check("rnd.retired", retired_count, m_cnt);
    end

`ifdef CONTROL_UNIT_PERF_CNT_EN
    @(negedge clock);
    reset = 1'b1;
    state = ST_IDLE;
    @(negedge clock);
    reset = 1'b0;
    state = ST_F3;
    repeat (65534) @(posedge clock);
    #1 check("sat.FFFE", retired_count, 16'hFFFE);
    @(posedge clock);
    #1 check("sat.FFFF", retired_count, 16'hFFFF);
    repeat (2) @(posedge clock);
    #1 check("sat.hold", retired_count, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
